// File: rtl/rcn_copy_engine.sv
// rtl/rcn_copy_engine.sv - word-copy DMA engine driving the rcn bus master request/response interface
//
// Copies len 32-bit words from src_addr to dst_addr. Up to four reads are in
// flight at once; a 4-slot buffer indexed by seq absorbs out-of-order read
// responses, and writes drain the buffer strictly in order.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start/src_addr/dst_addr/len   copy command, taken only when idle
//   active, done             busy indication and one-cycle completion pulse
//   cs/seq/wr/mask/addr/wdata     registered request to the bus master
//   busy                     master stall; a request is taken on cs && !busy
//   rdone/wdone/rsp_seq/rsp_data  read and write responses from the master
module rcn_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [21:0]      src_addr,
    input  logic [21:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             active,
    output logic             done,
    output logic             cs,
    output logic [1:0]       seq,
    input  logic             busy,
    output logic             wr,
    output logic [3:0]       mask,
    output logic [21:0]      addr,
    output logic [31:0]      wdata,
    input  logic             rdone,
    input  logic             wdone,
    input  logic [1:0]       rsp_seq,
    input  logic [31:0]      rsp_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [19:0]      src_word_q, src_word_d, dst_word_q, dst_word_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, cmp_cnt_q, cmp_cnt_d;
    logic [2:0]       out_wr_q, out_wr_d;
    logic [3:0]       pend_q, pend_d, val_q, val_d;
    logic [31:0]      slot_q [4];
    logic [31:0]      slot_d [4];
    logic             cs_q, cs_d, wr_q, wr_d, active_q, active_d, done_q, done_d;
    logic [1:0]       seq_q, seq_d;
    logic [21:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             accept, rd_ready, wr_ready, wdone_ok;
    logic [1:0]       rd_slot, wr_slot;

    // Byte-offset bits of the command addresses carry no information.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        accept   = cs_q && !busy;
        rd_slot  = rd_cnt_q[1:0];
        wr_slot  = wr_cnt_q[1:0];
        rd_ready = (rd_cnt_q < len_q) && !pend_q[rd_slot] && !val_q[rd_slot];
        wr_ready = (wr_cnt_q < len_q) && val_q[wr_slot] && (out_wr_q != 3'd4);
        wdone_ok = wdone && (out_wr_q != 3'd0);

        state_d    = state_q;
        src_word_d = src_word_q;
        dst_word_d = dst_word_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        cmp_cnt_d  = cmp_cnt_q;
        pend_d     = pend_q;
        val_d      = val_q;
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end
        cs_d     = cs_q;
        wr_d     = wr_q;
        seq_d    = seq_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        active_d = active_q;
        done_d   = 1'b0;

        // Responses to slots that are not waiting (e.g. left over from before a
        // reset) are dropped.
        if (rdone && pend_q[rsp_seq]) begin
            slot_d[rsp_seq] = rsp_data;
            pend_d[rsp_seq] = 1'b0;
            val_d[rsp_seq]  = 1'b1;
        end
        if (wdone_ok) begin
            cmp_cnt_d = cmp_cnt_q + LEN_W'(1);
        end

        if (accept) begin
            cs_d = 1'b0;
            if (wr_q) begin
                val_d[seq_q] = 1'b0;
                wr_cnt_d     = wr_cnt_q + LEN_W'(1);
            end else begin
                pend_d[seq_q] = 1'b1;
                rd_cnt_d      = rd_cnt_q + LEN_W'(1);
            end
        end

        // Write acceptance and write completion in the same cycle cancel out.
        case ({accept && wr_q, wdone_ok})
            2'b10:   out_wr_d = out_wr_q + 3'd1;
            2'b01:   out_wr_d = out_wr_q - 3'd1;
            default: out_wr_d = out_wr_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_word_d = src_addr[21:2];
                    dst_word_d = dst_addr[21:2];
                    len_d      = len;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    cmp_cnt_d  = '0;
                    out_wr_d   = 3'd0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                        active_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A new request is chosen only while no request is held, so the
                // counters and slot bits already reflect the last acceptance.
                if (!cs_q) begin
                    if (rd_cnt_q == len_q && wr_cnt_q == len_q) begin
                        state_d = S_DRAIN;
                    end else if (wr_ready) begin
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        seq_d   = wr_slot;
                        addr_d  = {dst_word_q + 20'(wr_cnt_q), 2'b00};
                        wdata_d = slot_q[wr_slot];
                    end else if (rd_ready) begin
                        cs_d    = 1'b1;
                        wr_d    = 1'b0;
                        seq_d   = rd_slot;
                        addr_d  = {src_word_q + 20'(rd_cnt_q), 2'b00};
                        wdata_d = 32'd0;
                    end
                end
            end
            S_DRAIN: begin
                if (cmp_cnt_q == len_q) begin
                    state_d  = S_DONE;
                    active_d = 1'b0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            src_word_q <= '0;
            dst_word_q <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            cmp_cnt_q  <= '0;
            out_wr_q   <= 3'd0;
            pend_q     <= 4'd0;
            val_q      <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= 32'd0;
            end
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            seq_q      <= 2'd0;
            addr_q     <= 22'd0;
            wdata_q    <= 32'd0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_word_q <= src_word_d;
            dst_word_q <= dst_word_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            cmp_cnt_q  <= cmp_cnt_d;
            out_wr_q   <= out_wr_d;
            pend_q     <= pend_d;
            val_q      <= val_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            seq_q      <= seq_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign active = active_q;
    assign done   = done_q;
    assign cs     = cs_q;
    assign seq    = seq_q;
    assign wr     = wr_q;
    assign mask   = 4'hF;
    assign addr   = addr_q;
    assign wdata  = wdata_q;

endmodule

// File: tb/tb_rcn_copy_engine.sv
// tb/tb_rcn_copy_engine.sv - scoreboard testbench for rcn_copy_engine
module tb_rcn_copy_engine;

    typedef struct {
        logic [1:0]  seq;
        logic [21:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [21:0] src_addr = 22'd0;
    logic [21:0] dst_addr = 22'd0;
    logic [15:0] len = 16'd0;
    logic        busy = 1'b0;
    logic        rdone, wdone;
    logic [1:0]  rsp_seq;
    logic [31:0] rsp_data;
    logic        active, done, cs, wr;
    logic [1:0]  seq;
    logic [3:0]  mask;
    logic [21:0] addr;
    logic [31:0] wdata;

    int total = 0;
    int bad = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_done = 0;
    int done_base = 0;
    bit hold_rd = 1'b0;
    bit hold_wr = 1'b0;

    req_t exp_rd[$];
    req_t exp_wr[$];
    req_t rq[$];
    req_t wq[$];
    logic [1:0] man_q[$];

    rcn_copy_engine #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .active(active), .done(done), .cs(cs), .seq(seq), .busy(busy),
        .wr(wr), .mask(mask), .addr(addr), .wdata(wdata), .rdone(rdone), .wdone(wdone),
        .rsp_seq(rsp_seq), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return {10'h2A5, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: every accepted request is compared with the next
    // expected read or write and handed to the responder.
    initial begin
        req_t e;
        req_t r;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (rst && cs && !busy) begin
                r.seq  = seq;
                r.addr = addr;
                r.data = mem_word(addr);
                check("req_mask", mask, 4'hF);
                if (!wr) begin
                    n_rd++;
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", 1, 0);
                    end else begin
                        e = exp_rd.pop_front();
                        check("rd_addr", addr, e.addr);
                        check("rd_seq", seq, e.seq);
                    end
                    rq.push_back(r);
                end else begin
                    n_wr++;
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", addr, e.addr);
                        check("wr_seq", seq, e.seq);
                        check("wr_data", wdata, e.data);
                    end
                    wq.push_back(r);
                end
            end
        end
    end

    // Responder: answers one read and one write per cycle. While hold_rd is set,
    // reads are answered only in the seq order listed in man_q.
    initial begin
        int idx;
        rdone = 1'b0; wdone = 1'b0; rsp_seq = 2'd0; rsp_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            rdone = 1'b0;
            wdone = 1'b0;
            idx = -1;
            if (rq.size() > 0) begin
                if (!hold_rd) begin
                    idx = 0;
                end else if (man_q.size() > 0) begin
                    for (int i = 0; i < rq.size(); i++) begin
                        if (idx < 0 && rq[i].seq == man_q[0]) idx = i;
                    end
                    if (idx >= 0) void'(man_q.pop_front());
                end
            end
            if (idx >= 0) begin
                rdone    = 1'b1;
                rsp_seq  = rq[idx].seq;
                rsp_data = rq[idx].data;
                rq.delete(idx);
            end
            if (!hold_wr && wq.size() > 0) begin
                wdone = 1'b1;
                if (idx < 0) rsp_seq = wq[0].seq;
                void'(wq.pop_front());
            end
        end
    end

    task automatic push_copy(input logic [21:0] s, input logic [21:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            logic [19:0] sw;
            logic [19:0] dw;
            req_t e;
            sw = s[21:2] + 20'(k);
            dw = d[21:2] + 20'(k);
            e.seq  = 2'(k);
            e.addr = {sw, 2'b00};
            e.data = 32'd0;
            exp_rd.push_back(e);
            e.addr = {dw, 2'b00};
            e.data = mem_word({sw, 2'b00});
            exp_wr.push_back(e);
        end
    endtask

    task automatic start_copy(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n);
        @(posedge clk);
        #1;
        src_addr  = s;
        dst_addr  = d;
        len       = n;
        start     = 1'b1;
        done_base = n_done;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c;
        c = 0;
        while (n_done == done_base && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({name, "_done_seen"}, (n_done != done_base), 1);
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, n_done - done_base, 1);
        check({name, "_active_low"}, active, 0);
        check({name, "_rd_left"}, exp_rd.size(), 0);
        check({name, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        int rb;
        int wb;
        int c;

        // Reset state
        #2;
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_cs", cs, 0);
        check("rst_wr", wr, 0);
        check("rst_seq", seq, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic in-order copy
        rb = n_rd; wb = n_wr;
        push_copy(22'h000100, 22'h000800, 4);
        start_copy(22'h000100, 22'h000800, 16'd4);
        @(negedge clk);
        check("basic_active_high", active, 1);
        wait_done(200, "basic");
        check("basic_nrd", n_rd - rb, 4);
        check("basic_nwr", n_wr - wb, 4);

        // Out-of-order read responses 2,0,3,1
        hold_rd = 1'b1;
        rb = n_rd; wb = n_wr;
        push_copy(22'h000100, 22'h000800, 4);
        start_copy(22'h000100, 22'h000800, 16'd4);
        c = 0;
        while (n_rd - rb < 4 && c < 60) begin @(negedge clk); c++; end
        check("ooo_four_reads", n_rd - rb, 4);
        man_q.push_back(2'd2);
        repeat (5) @(negedge clk);
        check("ooo_no_early_write", n_wr - wb, 0);
        man_q.push_back(2'd0);
        man_q.push_back(2'd3);
        man_q.push_back(2'd1);
        c = 0;
        while ((man_q.size() > 0 || rq.size() > 0) && c < 60) begin @(negedge clk); c++; end
        hold_rd = 1'b0;
        wait_done(200, "ooo");

        // Backpressure
        busy = 1'b1;
        rb = n_rd; wb = n_wr;
        push_copy(22'h000200, 22'h000A00, 8);
        start_copy(22'h000200, 22'h000A00, 16'd8);
        c = 0;
        while (!cs && c < 10) begin @(negedge clk); c++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_cs", cs, 1);
            check("bp_addr", addr, 22'h000200);
            check("bp_seq", seq, 0);
            check("bp_wr", wr, 0);
            check("bp_wdata", wdata, 0);
        end
        check("bp_no_accept", n_rd - rb, 0);
        @(posedge clk);
        #1;
        busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_one_accept", n_rd - rb, 1);
        check("bp_cs_dropped", cs, 0);
        wait_done(400, "bp");
        check("bp_nrd", n_rd - rb, 8);
        check("bp_nwr", n_wr - wb, 8);

        // Zero length
        rb = n_rd; wb = n_wr;
        start_copy(22'h000300, 22'h000900, 16'd0);
        @(negedge clk);
        check("zero_done_t1", done, 0);
        check("zero_cs_t1", cs, 0);
        @(negedge clk);
        check("zero_done_t2", done, 1);
        check("zero_active", active, 0);
        @(negedge clk);
        check("zero_done_t3", done, 0);
        check("zero_no_req", (n_rd - rb) + (n_wr - wb), 0);

        // Source pointer wrap
        push_copy(22'h3FFFFC, 22'h000040, 2);
        start_copy(22'h3FFFFC, 22'h000040, 16'd2);
        wait_done(200, "wrap");

        // Window limit, with an ignored start while running
        hold_rd = 1'b1;
        rb = n_rd; wb = n_wr;
        push_copy(22'h001000, 22'h002000, 8);
        start_copy(22'h001000, 22'h002000, 16'd8);
        repeat (30) @(negedge clk);
        check("win_four_reads", n_rd - rb, 4);
        check("win_cs_low", cs, 0);
        @(posedge clk);
        #1;
        src_addr = 22'h111100; len = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hold_rd = 1'b0;
        wait_done(400, "win");
        check("win_nrd", n_rd - rb, 8);
        check("win_nwr", n_wr - wb, 8);

        // Reset mid-copy
        push_copy(22'h004000, 22'h005000, 16);
        start_copy(22'h004000, 22'h005000, 16'd16);
        rb = n_rd;
        c = 0;
        while (n_rd - rb < 5 && c < 100) begin @(negedge clk); c++; end
        check("rstmid_progress", (n_rd - rb >= 5), 1);
        hold_rd = 1'b1;
        hold_wr = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_active", active, 0);
        check("rstmid_cs", cs, 0);
        check("rstmid_wr", wr, 0);
        check("rstmid_seq", seq, 0);
        check("rstmid_addr", addr, 0);
        check("rstmid_wdata", wdata, 0);
        check("rstmid_done", done, 0);
        exp_rd.delete();
        exp_wr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        hold_rd = 1'b0;
        hold_wr = 1'b0;
        done_base = n_done;
        c = 0;
        while ((rq.size() > 0 || wq.size() > 0) && c < 60) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        check("late_cs", cs, 0);
        check("late_active", active, 0);
        check("late_no_done", n_done - done_base, 0);
        rb = n_rd; wb = n_wr;
        push_copy(22'h006000, 22'h007000, 2);
        start_copy(22'h006000, 22'h007000, 16'd2);
        wait_done(200, "after_rst");
        check("after_rst_nrd", n_rd - rb, 2);
        check("after_rst_nwr", n_wr - wb, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcn_copy_engine.md
Name: rcn_copy_engine

Overview:
- Word-copy DMA engine that sits directly upstream of the buffered rcn bus master. It drives that master's request interface (cs/seq/wr/mask/addr/wdata/busy) and consumes its response interface (rdone/wdone/rsp_seq/rsp_data).
- It reads len words from a source region and writes them to a destination region.
- Up to 4 reads are outstanding at once. A 4-entry reorder buffer, indexed by seq, absorbs out-of-order read responses.
- Writes are issued strictly in order.

Parameters:
LEN_W, 16, width of the word-count input and of the internal read/write/completion counters.

Ports:
clk  input  1  clock
rst  input  1  reset. One clock; reset is asynchronous and active-low.
start  input  1  single-cycle pulse; accepted only in IDLE
src_addr  input  22  source byte address; bits [1:0] ignored
dst_addr  input  22  destination byte address; bits [1:0] ignored
len  input  LEN_W  number of 32-bit words to copy
active  output  1  high from start acceptance until done
done  output  1  single-cycle pulse at completion
cs  output  1  request valid to master
seq  output  2  request tag
busy  input  1  master cannot accept this cycle; a request is taken when cs && !busy
wr  output  1  1 = write, 0 = read
mask  output  4  always 4'hF
addr  output  22  request byte address, bits [1:0] = 0
wdata  output  32  write data
rdone  input  1  read response valid
wdone  input  1  write response valid
rsp_seq  input  2  response tag
rsp_data  input  32  read data

Behaviour:
- Reset values: active=0, done=0, cs=0, wr=0, seq=0, addr=0, wdata=0. All counters, slot-valid and slot-pending bits are cleared.
- States:
  - IDLE: start is latched. Source and destination word pointers are loaded from addr[21:2] of src_addr/dst_addr. Read, write and write-completion counters are cleared. Go to RUN; if len==0, go to DONE.
  - RUN: issue requests until len reads and len writes have been accepted, then go to DRAIN.
  - DRAIN: wait until write completions == len, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - active=1 in RUN and DRAIN.
- start outside IDLE is ignored.
- Slots: 4 entries, each with a pending bit, a valid bit and a data word.
  - Read k uses seq = k[1:0]. It may issue only if slot[k[1:0]] is neither pending nor valid. On acceptance, pending is set.
  - rdone with a pending slot[rsp_seq]: store rsp_data, clear pending, set valid.
  - rdone to a non-pending slot is ignored.
- Writes:
  - Write j uses slot[j[1:0]] and seq = j[1:0]. It may issue when that slot is valid and fewer than 4 writes are outstanding.
  - On acceptance, the slot's valid bit is cleared. Freeing a slot is visible to read issue in the next cycle.
  - wdone increments the completion counter and decrements the outstanding-write count. A wdone that arrives with 0 outstanding writes is ignored.
- Arbitration: one request per cycle. A ready write has priority over a ready read.
- Request hold: cs and the request fields are registered. While cs && busy, all request fields stay stable. The next request is selected only in the cycle after acceptance.
- Issue-to-cs latency is 1 cycle.
- Addresses:
  - Read k: addr = {(src_word + k) mod 2^20, 2'b00}.
  - Write j: addr = {(dst_word + j) mod 2^20, 2'b00}. Pointers wrap silently.
- Simultaneous events:
  - rdone and wdone in the same cycle are both processed.
  - A write acceptance and an rdone to a different slot in the same cycle are both processed.
  - A write acceptance and a wdone in the same cycle leave the outstanding-write count unchanged.
- Reset mid-operation returns to IDLE with all state cleared. Late responses after reset hit non-pending slots or a zero outstanding-write count and are dropped.
- Overlapping source and destination regions are not checked. The copy result follows issue order.

Test Plan:
- Basic copy: src=0x000100, dst=0x000800, len=4, busy=0, in-order 1-cycle responses → reads to 0x100/0x104/0x108/0x10C with seq 0–3, then writes to 0x800–0x80C carrying the matching data. done pulses once after the 4th wdone; active is low afterwards.
- Out-of-order responses: len=4, reads answered in rsp_seq order 2,0,3,1 → writes still issue in order 0x800,0x804,0x808,0x80C with the correct data. No write issues before its slot is valid.
- Backpressure: busy held high for 5 cycles while cs=1 → addr/seq/wr/wdata stay stable. Exactly one acceptance when busy drops. len=8 completes with 8 reads and 8 writes.
- Zero length and wrap: len=0 → done pulses 2 cycles after start with no cs. src=0x3FFFFC, len=2 → read addresses 0x3FFFFC then 0x000000.
- Window limit: len=8 with rdone withheld → exactly 4 reads issue, then cs stays low. Releasing the responses resumes issue; the copy finishes.
- Reset mid-copy: assert rst low during RUN of a len=16 copy → all outputs return to reset values immediately. A following rdone/wdone causes no state change. A new start with len=2 completes normally.
